mam_wb_if_pipe: RTL
===================

// Module: mam_wb_if_pipe
// PURPOSE
// MAM-to-Wishbone B3 master bridge, successor to the single-beat-buffered MAM bus interface. Adds:
//   - SEL_O byte lanes on every write beat
//   - wrapping bursts (BTE)
//   - ERR_I termination with status reporting
//   - RD_FIFO_DEPTH-deep read prefetch FIFO, so reads keep streaming while the MAM consumer stalls
// Sits between the MAM request/data handshakes and the system Wishbone bus.
// PARAMETERS
// DATA_WIDTH     32  data bits; multiple of 8
// ADDR_WIDTH     32  byte address bits
// BEATS_WIDTH    14  width of req_beats
// RD_FIFO_DEPTH  4   read FIFO entries; power of 2, >=2
// PORTS
// CLK_I        in   1              clock
// RST_NI       in   1              reset, asynchronous, active-low
// req_valid    in   1              new request
// req_ready    out  1              request accepted (high only in IDLE)
// req_rw       in   1              0 read, 1 write
// req_addr     in   ADDR_WIDTH     start byte address, DATA_WIDTH/8 aligned
// req_burst    in   1              0 single, 1 burst
// req_beats    in   BEATS_WIDTH    burst length in words; 0 treated as 1
// req_wrap     in   2              00 linear, 01 wrap4, 10 wrap8, 11 wrap16
// write_valid  in   1              write beat valid
// write_data   in   DATA_WIDTH     write data
// write_strb   in   DATA_WIDTH/8   byte enables, per beat
// write_ready  out  1              write beat consumed
// read_valid   out  1              read beat valid (FIFO not empty)
// read_data    out  DATA_WIDTH     FIFO head, first-word fall-through
// read_ready   in   1              read beat consumed
// err          out  1              last/current transfer saw ERR_I; cleared on next req accept
// CYC_O,STB_O,WE_O  out  1         Wishbone cycle/strobe/write enable
// ADDR_O       out  ADDR_WIDTH     Wishbone address
// DAT_O        out  DATA_WIDTH     Wishbone write data
// SEL_O        out  DATA_WIDTH/8   Wishbone byte select
// CTI_O        out  3              Wishbone cycle type
// BTE_O        out  2              Wishbone burst type
// DAT_I        in   DATA_WIDTH     Wishbone read data
// ACK_I,ERR_I  in   1              Wishbone terminations
// BEHAVIOUR
// Reset (async):
//   - state IDLE; FIFO emptied; err=0
//   - all Wishbone outputs 0
//   - read_valid=0, write_ready=0
// States:
//   - IDLE: req_ready=1. req_valid: latch rw/addr/beats/wrap; CYC_O=1 at t+1; go WR or RD.
//   - WR: one-entry hold register (data, strb).
//     - write_ready = !hold_full | (STB_O & ACK_I).
//     - STB_O=1 while hold_full. First STB_O is t+2 earliest.
//     - DAT_O/SEL_O come from the hold register.
//   - RD: STB_O=1 while beats_left>0 and fifo_count+1<=RD_FIFO_DEPTH.
//     - Each ACK_I pushes DAT_I into the FIFO.
//     - If FIFO count+1 would exceed depth, STB_O drops the next cycle; CYC_O stays high.
//   - DRAIN: all beats issued; CYC_O=0; wait until FIFO empty, then IDLE.
//   - WR returns to IDLE the cycle after the last ACK_I.
// Wishbone signalling:
//   - CTI_O: single 000; burst non-last 010; last beat 111. Changes only after ACK.
//   - BTE_O = req_wrap for bursts, 00 for single.
// Address after each ACK:
//   - linear: +DATA_WIDTH/8.
//   - wrapN: low log2(N*DATA_WIDTH/8) bits increment modulo the block; upper bits held.
//   - Wrap past the top of the address space is modulo 2^ADDR_WIDTH.
// ERR_I (with STB_O):
//   - treated as termination; err=1; CYC_O/STB_O=0 next cycle.
//   - Remaining write beats are accepted and discarded (write_ready=1).
//   - Remaining read beats are pushed as 0 data, so the consumer sees exactly req_beats beats.
// Simultaneous events:
//   - FIFO push and pop in the same cycle leave the count unchanged.
//   - ACK_I and ERR_I together count as ERR.
//   - ACK_I without STB_O is ignored.
// TESTING
// single write addr=0x100 strb=0x3 -> one STB, WE=1, SEL_O=0x3, CTI=000; IDLE after ACK
// burst read 8 beats, linear, read_ready=1, ACK every cycle -> 8 beats in order; CTI 010x7 then 111
// burst read 8 beats, depth 4, read_ready=0 -> STB_O drops after 4 ACKs; read_ready=1 -> resumes; 8 beats delivered
// wrap4 burst write at 0x18, DATA_WIDTH=32 -> ADDR_O 0x18,0x1C,0x10,0x14; BTE=01
// ERR_I on beat 2 of a 4-beat read -> err=1, CYC_O=0; consumer gets beat1 data plus 3 zero beats
// RST_NI low mid-burst -> all outputs 0 immediately; next req_valid accepted normally

Source files
------------

// File: rtl/mam_wb_if_pipe_if.sv
// Wishbone B3 master-side bus bundle for the MAM bridge; the master modport is
// the bridge's view, the slave modport the interconnect/peripheral view.
interface mam_wb_if_pipe_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                    CYC_O;
  logic                    STB_O;
  logic                    WE_O;
  logic [ADDR_WIDTH-1:0]   ADDR_O;
  logic [DATA_WIDTH-1:0]   DAT_O;
  logic [DATA_WIDTH/8-1:0] SEL_O;
  logic [2:0]              CTI_O;
  logic [1:0]              BTE_O;
  logic [DATA_WIDTH-1:0]   DAT_I;
  logic                    ACK_I;
  logic                    ERR_I;

  modport master (
    output CYC_O, STB_O, WE_O, ADDR_O, DAT_O, SEL_O, CTI_O, BTE_O,
    input  DAT_I, ACK_I, ERR_I
  );

  modport slave (
    input  CYC_O, STB_O, WE_O, ADDR_O, DAT_O, SEL_O, CTI_O, BTE_O,
    output DAT_I, ACK_I, ERR_I
  );
endinterface

// File: rtl/mam_wb_if_pipe.sv
// MAM request/data handshakes to Wishbone B3 master: byte-lane writes through a
// one-entry hold register, wrapping bursts, ERR_I reporting, read prefetch FIFO.
module mam_wb_if_pipe #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned BEATS_WIDTH   = 14,
  parameter int unsigned RD_FIFO_DEPTH = 4
) (
  input  logic                    CLK_I,
  input  logic                    RST_NI,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_rw,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_burst,
  input  logic [BEATS_WIDTH-1:0]  req_beats,
  input  logic [1:0]              req_wrap,
  input  logic                    write_valid,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] write_strb,
  output logic                    write_ready,
  output logic                    read_valid,
  output logic [DATA_WIDTH-1:0]   read_data,
  input  logic                    read_ready,
  output logic                    err,
  mam_wb_if_pipe_if.master        wb
);
  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned PW    = $clog2(RD_FIFO_DEPTH);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WR    = 2'd1;
  localparam logic [1:0] S_RD    = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
  localparam logic [PW:0]            FIFO_FULL = (PW+1)'(RD_FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0]  STEP      = ADDR_WIDTH'(BYTES);
  localparam logic [BEATS_WIDTH-1:0] ONE       = BEATS_WIDTH'(1);

  logic [1:0]              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    burst_q, burst_d;
  logic [1:0]              wrap_q, wrap_d;
  logic [BEATS_WIDTH-1:0]  beats_left_q, beats_left_d;
  logic [BEATS_WIDTH-1:0]  acc_left_q, acc_left_d;
  logic                    err_q, err_d;
  logic                    hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0]   hold_data_q, hold_data_d;
  logic [DATA_WIDTH/8-1:0] hold_strb_q, hold_strb_d;
  logic [DATA_WIDTH-1:0]   fifo_q [RD_FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [PW:0]             count_q;

  logic                    cyc, stb, term, err_now, ack_ok, fill, push, pop, wr_take;
  logic [DATA_WIDTH-1:0]   push_data;
  logic [ADDR_WIDTH-1:0]   wmask, addr_inc, addr_nxt;
  logic [BEATS_WIDTH-1:0]  beats_req;

  assign cyc = (state_q == S_WR || state_q == S_RD) && !err_q;
  assign stb = (state_q == S_WR && hold_full_q && !err_q) ||
               (state_q == S_RD && !err_q && beats_left_q != '0 && count_q < FIFO_FULL);
  assign term    = stb && (wb.ACK_I || wb.ERR_I);
  assign err_now = stb && wb.ERR_I;
  assign ack_ok  = term && !wb.ERR_I;

  // After an error, outstanding read beats are still pushed (as zeros) so the
  // consumer always receives the requested beat count.
  assign fill      = state_q == S_RD && err_q && beats_left_q != '0 && count_q < FIFO_FULL;
  assign push      = (state_q == S_RD) && (term || fill);
  assign push_data = ack_ok ? wb.DAT_I : '0;
  assign read_valid = count_q != '0;
  assign read_data  = fifo_q[rd_ptr_q];
  assign pop        = read_valid && read_ready;

  assign write_ready = state_q == S_WR && acc_left_q != '0 && (!hold_full_q || term || err_q);
  assign wr_take     = write_ready && write_valid;
  assign req_ready   = state_q == S_IDLE;
  assign err         = err_q;
  assign beats_req   = (!req_burst || req_beats == '0) ? ONE : req_beats;

  always_comb begin
    case (wrap_q)
      2'b01:   wmask = ADDR_WIDTH'(4 * BYTES - 1);
      2'b10:   wmask = ADDR_WIDTH'(8 * BYTES - 1);
      2'b11:   wmask = ADDR_WIDTH'(16 * BYTES - 1);
      default: wmask = '0;
    endcase
    addr_inc = addr_q + STEP;
    addr_nxt = (wrap_q == 2'b00) ? addr_inc : ((addr_q & ~wmask) | (addr_inc & wmask));
  end

  assign wb.CYC_O  = cyc;
  assign wb.STB_O  = stb;
  assign wb.WE_O   = cyc && state_q == S_WR;
  assign wb.ADDR_O = addr_q;
  assign wb.DAT_O  = hold_data_q;
  assign wb.SEL_O  = hold_strb_q;
  assign wb.CTI_O  = !cyc ? 3'b000 : !burst_q ? 3'b000 : (beats_left_q == ONE) ? 3'b111 : 3'b010;
  assign wb.BTE_O  = cyc ? wrap_q : 2'b00;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    burst_d      = burst_q;
    wrap_d       = wrap_q;
    beats_left_d = beats_left_q;
    acc_left_d   = acc_left_q;
    err_d        = err_q;
    hold_full_d  = hold_full_q;
    hold_data_d  = hold_data_q;
    hold_strb_d  = hold_strb_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        state_d      = req_rw ? S_WR : S_RD;
        addr_d       = req_addr;
        burst_d      = req_burst;
        wrap_d       = req_burst ? req_wrap : 2'b00;
        beats_left_d = beats_req;
        acc_left_d   = req_rw ? beats_req : '0;
        err_d        = 1'b0;
        hold_full_d  = 1'b0;
      end
      S_WR: begin
        acc_left_d = acc_left_q - BEATS_WIDTH'(wr_take);
        // Beats taken in or after the error cycle are discarded, not held.
        if (wr_take && !err_q && !err_now) begin
          hold_full_d = 1'b1;
          hold_data_d = write_data;
          hold_strb_d = write_strb;
        end else if (term || err_q) begin
          hold_full_d = 1'b0;
        end
        if (err_now) begin
          beats_left_d = '0;
        end else if (ack_ok) begin
          beats_left_d = beats_left_q - ONE;
          addr_d       = addr_nxt;
        end
        if (beats_left_d == '0 && acc_left_d == '0) state_d = S_IDLE;
      end
      S_RD: if (push) begin
        beats_left_d = beats_left_q - ONE;
        if (ack_ok) addr_d = addr_nxt;
        if (beats_left_d == '0) state_d = S_DRAIN;
      end
      default: if (count_q == '0) state_d = S_IDLE;
    endcase
    if (err_now) err_d = 1'b1;
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      burst_q      <= 1'b0;
      wrap_q       <= 2'b00;
      beats_left_q <= '0;
      acc_left_q   <= '0;
      err_q        <= 1'b0;
      hold_full_q  <= 1'b0;
      hold_data_q  <= '0;
      hold_strb_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      burst_q      <= burst_d;
      wrap_q       <= wrap_d;
      beats_left_q <= beats_left_d;
      acc_left_q   <= acc_left_d;
      err_q        <= err_d;
      hold_full_q  <= hold_full_d;
      hold_data_q  <= hold_data_d;
      hold_strb_q  <= hold_strb_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (push) fifo_q[wr_ptr_q] <= push_data;
  end
endmodule
